// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin grant with locked bursts of up to BURST_MAX beats.
// Defining DMEM_ARB_FIXED_PRIO_EN makes port 0 win every idle tie instead.
module dmem_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0] BMAX     = 4'(BURST_MAX);
    localparam logic       CAN_LOCK = (BURST_MAX > 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cnt_inc;
    logic        rvalid0_q, rvalid1_q;
    logic        err0_q, err1_q;
    logic [31:0] rdata0_q, rdata1_q;
    logic        al0, al1;
    logic        rd_beat0, rd_beat1;

    assign al0      = (addr0[1:0] == 2'b00);
    assign al1      = (addr1[1:0] == 2'b00);
    assign cnt_inc  = cnt_q + 4'd1;
    assign rd_beat0 = gnt0 && !we0 && al0;
    assign rd_beat1 = gnt1 && !we1 && al1;

    // Grants are combinational and forced low while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                        gnt0 = 1'b1;
`else
                        if (last_q) gnt0 = 1'b1;
                        else        gnt1 = 1'b1;
`endif
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                OWN0:    gnt0 = req0 && lock0;
                OWN1:    gnt1 = req1 && lock1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt0) begin
                    if (lock0 && CAN_LOCK) begin
                        state_d = OWN0;
                        cnt_d   = 4'd1;
                    end else begin
                        last_d = 1'b0;
                    end
                end else if (gnt1) begin
                    if (lock1 && CAN_LOCK) begin
                        state_d = OWN1;
                        cnt_d   = 4'd1;
                    end else begin
                        last_d = 1'b1;
                    end
                end
            end
            OWN0: begin
                if (gnt0 && cnt_inc != BMAX) begin
                    cnt_d = cnt_inc;
                end else begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                    cnt_d   = 4'd0;
                end
            end
            OWN1: begin
                if (gnt1 && cnt_inc != BMAX) begin
                    cnt_d = cnt_inc;
                end else begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Misaligned beats are consumed but never write and never return data.
    assign mem_a  = gnt1 ? addr1 : addr0;
    assign mem_wd = gnt1 ? wdata1 : wdata0;
    assign mem_we = (gnt0 && we0 && al0) || (gnt1 && we1 && al1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= 4'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= rd_beat0;
            rvalid1_q <= rd_beat1;
            err0_q    <= gnt0 && !al0;
            err1_q    <= gnt1 && !al1;
            if (rd_beat0) rdata0_q <= mem_rd;
            if (rd_beat1) rdata1_q <= mem_rd;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule
